regfile_wb_arbiter: RTL and testbench

Shares the single write port of the 32x32 register file between two requesters: the pipeline writeback stage (fixed priority, no backpressure) and a multi-cycle multiply/divide unit (MDU, valid/ready handshake). It also keeps a busy scoreboard of registers with an MDU result outstanding, so the hazard logic can stall on them. It raises a pipeline stall to guarantee MDU forward progress, and it filters every write to register 0.

---
 rtl/regfile_wb_arbiter.sv | 101 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter: pipeline writeback vs. multi-cycle MDU.
// Tracks MDU-pending destinations and forces a WB bubble when the MDU starves.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mdu_issue,
    input  logic [4:0]        mdu_issue_addr,
    input  logic              mdu_valid,
    output logic              mdu_ready,
    input  logic [4:0]        mdu_addr,
    input  logic [DATA_W-1:0] mdu_data,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic              pipe_stall,
    output logic              proto_err
);

    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

    logic [31:0] busy;
    logic [31:0] busy_nxt;
    logic [3:0]  wait_cnt;
    logic        a_act;
    logic        hs;
    logic        blocked;
    logic        iss_act;
    logic        waw;

    assign a_act     = wb_we && (wb_addr != 5'd0);
    assign mdu_ready = !a_act;
    assign hs        = mdu_valid && mdu_ready;
    assign blocked   = mdu_valid && !mdu_ready;
    assign iss_act   = mdu_issue && (mdu_issue_addr != 5'd0);
    assign waw       = iss_act && busy[mdu_issue_addr];

    assign rs_busy = busy[rs_addr];
    assign rt_busy = busy[rt_addr];

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = '0;
        if (a_act) begin
            rf_we    = 1'b1;
            rf_waddr = wb_addr;
            rf_wdata = wb_data;
        end else if (hs && (mdu_addr != 5'd0)) begin
            rf_we    = 1'b1;
            rf_waddr = mdu_addr;
            rf_wdata = mdu_data;
        end
    end

    // Set is applied after clear so a same-cycle issue to the retiring reg wins.
    always_comb begin
        busy_nxt = busy;
        if (hs)
            busy_nxt[mdu_addr] = 1'b0;
        if (iss_act)
            busy_nxt[mdu_issue_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= '0;
            wait_cnt   <= 4'd0;
            pipe_stall <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            busy <= busy_nxt;

            if (blocked) begin
                if (wait_cnt != LIM)
                    wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= 4'd0;
            end

            if (hs)
                pipe_stall <= 1'b0;
            else if (blocked && (wait_cnt == LIM - 4'd1))
                pipe_stall <= 1'b1;

            if (waw || (a_act && pipe_stall))
                proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Vector-table bench for regfile_wb_arbiter with an expected-value queue.
// Inputs change 1 time unit after posedge; outputs are checked on negedge.
module tb_regfile_wb_arbiter;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        iss;
        logic [4:0]  ia;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        x_rdy;
        logic        x_we;
        logic [4:0]  x_wa;
        logic [31:0] x_wd;
        logic        x_rsb;
        logic        x_rtb;
        logic        x_st;
        logic        x_pe;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        mdu_issue = 1'b0;
    logic [4:0]  mdu_issue_addr = '0;
    logic        mdu_valid = 1'b0;
    logic        mdu_ready;
    logic [4:0]  mdu_addr = '0;
    logic [31:0] mdu_data = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  rs_addr = '0;
    logic [4:0]  rt_addr = '0;
    logic        rs_busy;
    logic        rt_busy;
    logic        pipe_stall;
    logic        proto_err;

    int total = 0;
    int bad = 0;
    vec_t exp_q[$];
    vec_t tv[$];

    regfile_wb_arbiter #(.STARVE_LIMIT(4), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .mdu_issue(mdu_issue), .mdu_issue_addr(mdu_issue_addr),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
        .mdu_addr(mdu_addr), .mdu_data(mdu_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_busy(rs_busy), .rt_busy(rt_busy),
        .pipe_stall(pipe_stall), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(
        logic we, logic [4:0] wa, logic [31:0] wd,
        logic iss, logic [4:0] ia,
        logic mv, logic [4:0] ma, logic [31:0] md,
        logic [4:0] rs, logic [4:0] rt,
        logic x_rdy, logic x_we, logic [4:0] x_wa,
        logic [31:0] x_wd, logic x_rsb, logic x_rtb,
        logic x_st, logic x_pe);
        vec_t r;
        r.we = we; r.wa = wa; r.wd = wd;
        r.iss = iss; r.ia = ia;
        r.mv = mv; r.ma = ma; r.md = md;
        r.rs = rs; r.rt = rt;
        r.x_rdy = x_rdy; r.x_we = x_we; r.x_wa = x_wa;
        r.x_wd = x_wd; r.x_rsb = x_rsb; r.x_rtb = x_rtb;
        r.x_st = x_st; r.x_pe = x_pe;
        return r;
    endfunction

    task automatic chk(string nm, int idx,
                       logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%h want=%h",
                     nm, idx, act, exp);
        end
    endtask

    task automatic idle();
        wb_we = 0; wb_addr = 0; wb_data = 0;
        mdu_issue = 0; mdu_issue_addr = 0;
        mdu_valid = 0; mdu_addr = 0; mdu_data = 0;
    endtask

    task automatic apply(vec_t t, int idx);
        vec_t e;
        @(posedge clk);
        #1;
        wb_we = t.we; wb_addr = t.wa; wb_data = t.wd;
        mdu_issue = t.iss; mdu_issue_addr = t.ia;
        mdu_valid = t.mv; mdu_addr = t.ma; mdu_data = t.md;
        rs_addr = t.rs; rt_addr = t.rt;
        exp_q.push_back(t);
        @(negedge clk);
        e = exp_q.pop_front();
        chk("mdu_ready", idx, 32'(mdu_ready), 32'(e.x_rdy));
        chk("rf_we", idx, 32'(rf_we), 32'(e.x_we));
        chk("rf_waddr", idx, 32'(rf_waddr), 32'(e.x_wa));
        chk("rf_wdata", idx, rf_wdata, e.x_wd);
        chk("rs_busy", idx, 32'(rs_busy), 32'(e.x_rsb));
        chk("rt_busy", idx, 32'(rt_busy), 32'(e.x_rtb));
        chk("pipe_stall", idx, 32'(pipe_stall), 32'(e.x_st));
        chk("proto_err", idx, 32'(proto_err), 32'(e.x_pe));
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        idle();
        #1;
        chk("rst_stall", 0, 32'(pipe_stall), 0);
        chk("rst_perr", 0, 32'(proto_err), 0);
        chk("rst_busy", 0, 32'(rs_busy), 0);
        chk("rst_ready", 0, 32'(mdu_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic arbitration, scoreboard and register-0 filtering.
        tv.push_back(v(0,0,0, 0,0, 1,5,32'hDEADBEEF, 5,0,
                       1,1,5,32'hDEADBEEF, 0,0,0,0));
        tv.push_back(v(1,3,32'h11, 0,0, 1,7,32'h77, 0,0,
                       0,1,3,32'h11, 0,0,0,0));
        tv.push_back(v(0,0,0, 0,0, 1,7,32'h77, 0,0,
                       1,1,7,32'h77, 0,0,0,0));
        tv.push_back(v(0,0,0, 1,9, 0,0,0, 9,0,
                       1,0,0,0, 0,0,0,0));
        tv.push_back(v(0,0,0, 0,0, 0,0,0, 9,9,
                       1,0,0,0, 1,1,0,0));
        tv.push_back(v(0,0,0, 0,0, 1,9,32'h99, 9,0,
                       1,1,9,32'h99, 1,0,0,0));
        tv.push_back(v(0,0,0, 1,9, 1,9,32'hAA, 9,0,
                       1,1,9,32'hAA, 0,0,0,0));
        tv.push_back(v(0,0,0, 0,0, 0,0,0, 9,0,
                       1,0,0,0, 1,0,0,0));
        tv.push_back(v(0,0,0, 0,0, 1,9,32'hBB, 9,0,
                       1,1,9,32'hBB, 1,0,0,0));
        tv.push_back(v(1,0,32'h55, 0,0, 0,0,0, 9,0,
                       1,0,0,0, 0,0,0,0));
        tv.push_back(v(0,0,0, 1,0, 1,0,32'h66, 0,9,
                       1,0,0,0, 0,0,0,0));
        tv.push_back(v(0,0,0, 0,0, 0,0,0, 0,0,
                       1,0,0,0, 0,0,0,0));
        tv.push_back(v(1,4,32'h44, 1,12, 0,0,0, 0,0,
                       0,1,4,32'h44, 0,0,0,0));
        tv.push_back(v(1,12,32'hC, 0,0, 0,0,0, 12,0,
                       0,1,12,32'hC, 1,0,0,0));
        tv.push_back(v(0,0,0, 0,0, 0,0,0, 12,12,
                       1,0,0,0, 1,1,0,0));
        tv.push_back(v(0,0,0, 1,12, 0,0,0, 12,0,
                       1,0,0,0, 1,0,0,0));
        tv.push_back(v(0,0,0, 0,0, 0,0,0, 12,0,
                       1,0,0,0, 1,0,0,1));
        tv.push_back(v(0,0,0, 0,0, 0,0,0, 0,12,
                       1,0,0,0, 0,1,0,1));
        for (int i = 0; i < tv.size(); i++)
            apply(tv[i], i);

        // Starvation: four blocked cycles raise the stall request.
        do_reset();
        for (int i = 0; i < 4; i++)
            apply(v(1,3,32'h11, 0,0, 1,7,32'h70, 0,0,
                    0,1,3,32'h11, 0,0,0,0), 100 + i);
        // WB write while stalled: WB wins, error flagged, stall holds.
        apply(v(1,3,32'h12, 0,0, 1,7,32'h70, 0,0,
                0,1,3,32'h12, 0,0,1,0), 104);
        apply(v(0,0,0, 0,0, 1,7,32'h70, 0,0,
                1,1,7,32'h70, 0,0,1,1), 105);
        apply(v(0,0,0, 0,0, 0,0,0, 0,0,
                1,0,0,0, 0,0,0,1), 106);

        // WAW error plus stall, then an asynchronous reset mid-stall.
        do_reset();
        apply(v(0,0,0, 1,4, 0,0,0, 4,0,
                1,0,0,0, 0,0,0,0), 200);
        apply(v(0,0,0, 1,4, 0,0,0, 4,0,
                1,0,0,0, 1,0,0,0), 201);
        for (int i = 0; i < 4; i++)
            apply(v(1,3,32'h1, 0,0, 1,8,32'h8, 4,0,
                    0,1,3,32'h1, 1,0,0,1), 202 + i);
        apply(v(0,0,0, 0,0, 0,0,0, 4,0,
                1,0,0,0, 1,0,1,1), 206);
        rst = 1'b1;
        #1;
        chk("arst_stall", 207, 32'(pipe_stall), 0);
        chk("arst_busy", 207, 32'(rs_busy), 0);
        chk("arst_perr", 207, 32'(proto_err), 0);
        @(negedge clk);
        idle();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_stall", 208, 32'(pipe_stall), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
